axis_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO for 8-bit AXI-Stream traffic, with TLAST carried alongside each byte. It sits directly downstream of the AXIS 2:1 mux and absorbs back-pressure bursts so the mux output stage can keep streaming while the consumer stalls. It also reports fill level and the number of complete packets currently held.

---
 rtl/axis_fifo.sv | 86 ++++++++
 tb/tb_axis_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo.sv
// First-word-fall-through FIFO for 8-bit AXI-Stream beats with TLAST; 1-cycle push-to-head latency.
// Back-pressure: TREADY_in drops only when full (or in reset); the head holds steady while TREADY_out is low.
module axis_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [7:0]        DATA_in,
  input  logic              TVALID_in,
  input  logic              TLAST_in,
  output logic              TREADY_in,
  output logic [7:0]        DATA_out,
  output logic              TVALID_out,
  output logic              TLAST_out,
  input  logic              TREADY_out,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W:0]   pkt_count
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [8:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [8:0]      head;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            pkt_inc;
  logic            pkt_dec;

  // Extra pointer MSB tells a wrapped-full pointer pair apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign TREADY_in  = !full && ARESETn;
  assign TVALID_out = !empty;

  assign head      = empty ? 9'd0 : mem[rd_ptr[ADDR_W-1:0]];
  assign DATA_out  = head[7:0];
  assign TLAST_out = head[8];

  assign push    = TVALID_in && TREADY_in;
  assign pop     = TVALID_out && TREADY_out;
  assign pkt_inc = push && TLAST_in;
  assign pkt_dec = pop && TLAST_out;

  // Storage is not reset; the pointers alone decide what is visible.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {TLAST_in, DATA_in};
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + CNT_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + CNT_ONE;
      end

      if (push && !pop) begin
        level <= level + CNT_ONE;
      end else if (pop && !push) begin
        level <= level - CNT_ONE;
      end

      if (pkt_inc && !pkt_dec) begin
        pkt_count <= pkt_count + CNT_ONE;
      end else if (pkt_dec && !pkt_inc) begin
        pkt_count <= pkt_count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench: a DEPTH=4 instance for most scenarios, a DEPTH=8 instance for the 6-beat packet count case.
module tb_axis_fifo;

  logic       aclk;
  logic       aresetn;
  logic [7:0] data_in;
  logic       tvalid_in;
  logic       tlast_in;
  logic       tready_out;

  logic       rdy4, vld4, last4;
  logic [7:0] dat4;
  logic [2:0] lvl4, pkt4;

  logic       rdy8, vld8, last8;
  logic [7:0] dat8;
  logic [3:0] lvl8, pkt8;

  int checks = 0;
  int errors = 0;

  axis_fifo #(.DEPTH(4)) u_dut4 (
    .ACLK(aclk), .ARESETn(aresetn),
    .DATA_in(data_in), .TVALID_in(tvalid_in), .TLAST_in(tlast_in), .TREADY_in(rdy4),
    .DATA_out(dat4), .TVALID_out(vld4), .TLAST_out(last4), .TREADY_out(tready_out),
    .level(lvl4), .pkt_count(pkt4)
  );

  axis_fifo #(.DEPTH(8)) u_dut8 (
    .ACLK(aclk), .ARESETn(aresetn),
    .DATA_in(data_in), .TVALID_in(tvalid_in), .TLAST_in(tlast_in), .TREADY_in(rdy8),
    .DATA_out(dat8), .TVALID_out(vld8), .TLAST_out(last8), .TREADY_out(tready_out),
    .level(lvl8), .pkt_count(pkt8)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic       rst_n;
    logic       vin;
    logic [7:0] din;
    logic       lin;
    logic       rout;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_dat;
    logic       e_last;
    logic [2:0] e_lvl;
    logic [2:0] e_pkt;
  } vec_t;

  vec_t vt [0:16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic rst_n, input logic vin, input logic [7:0] din,
                       input logic lin, input logic rout);
    @(negedge aclk);
    aresetn    = rst_n;
    tvalid_in  = vin;
    data_in    = din;
    tlast_in   = lin;
    tready_out = rout;
    #1;
  endtask

  task automatic check4(input string tag, input logic vld, input logic [7:0] dat,
                        input logic last, input logic [2:0] lvl, input logic [2:0] pkt);
    check({tag, " vld"},  16'(vld4),  16'(vld));
    check({tag, " dat"},  16'(dat4),  16'(dat));
    check({tag, " last"}, 16'(last4), 16'(last));
    check({tag, " lvl"},  16'(lvl4),  16'(lvl));
    check({tag, " pkt"},  16'(pkt4),  16'(pkt));
  endtask

  task automatic check8(input string tag, input logic [7:0] dat, input logic last,
                        input logic [3:0] lvl, input logic [3:0] pkt);
    check({tag, " dat8"},  16'(dat8),  16'(dat));
    check({tag, " last8"}, 16'(last8), 16'(last));
    check({tag, " lvl8"},  16'(lvl8),  16'(lvl));
    check({tag, " pkt8"},  16'(pkt8),  16'(pkt));
  endtask

  initial begin
    //          rst vin din    lin rout | rdy vld dat    last lvl pkt
    vt[0]  = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0};
    vt[1]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0};
    vt[2]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 3'd1, 3'd0};
    vt[3]  = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 3'd1, 3'd0};
    vt[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 3'd1, 3'd1};
    vt[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0};
    vt[6]  = '{1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0};
    vt[7]  = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 3'd1, 3'd0};
    vt[8]  = '{1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 3'd2, 3'd0};
    vt[9]  = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 3'd3, 3'd0};
    vt[10] = '{1'b1, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 3'd4, 3'd0};
    vt[11] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 3'd4, 3'd0};
    vt[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 3'd4, 3'd0};
    vt[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 3'd3, 3'd0};
    vt[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0, 3'd2, 3'd0};
    vt[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 3'd1, 3'd0};
    vt[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0};

    aresetn = 1'b0; tvalid_in = 1'b0; data_in = 8'h00; tlast_in = 1'b0; tready_out = 1'b0;
    repeat (2) @(posedge aclk);

    // Reset, pass-through, fill and drain
    for (int i = 0; i <= 16; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vt[i].rst_n, vt[i].vin, vt[i].din, vt[i].lin, vt[i].rout);
      check({tag, " rdy"}, 16'(rdy4), 16'(vt[i].e_rdy));
      check4(tag, vt[i].e_vld, vt[i].e_dat, vt[i].e_last, vt[i].e_lvl, vt[i].e_pkt);
    end

    // Steady push+pop at level 2 across several pointer wraps
    drive(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 1'b1, 8'hB2 + 8'(i), 1'b0, 1'b1);
      check4($sformatf("stream%0d", i), 1'b1, 8'hB0 + 8'(i), 1'b0, 3'd2, 3'd0);
      check($sformatf("stream%0d rdy", i), 16'(rdy4), 16'd1);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check4("stream_tail0", 1'b1, 8'hBE, 1'b0, 3'd2, 3'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check4("stream_tail1", 1'b1, 8'hBF, 1'b0, 3'd1, 3'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check4("stream_empty", 1'b0, 8'h00, 1'b0, 3'd0, 3'd0);

    // Packet counting on the 8-deep instance: packets of 2, 1, 3 beats
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hC1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 8'hC2, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hC4, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hC5, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check8("pkt_full", 8'hC0, 1'b0, 4'd6, 4'd3);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check8("pkt_pop0", 8'hC0, 1'b0, 4'd6, 4'd3);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check8("pkt_pop1", 8'hC1, 1'b1, 4'd5, 4'd3);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check8("pkt_pop2", 8'hC2, 1'b1, 4'd4, 4'd2);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check8("pkt_after3", 8'hC3, 1'b0, 4'd3, 4'd1);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'hD0, 1'b1, 1'b1);
    check8("pkt_swap_before", 8'hC5, 1'b1, 4'd1, 4'd1);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check8("pkt_swap_after", 8'hD0, 1'b1, 4'd1, 4'd1);

    // Reset with a partial packet held
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hE0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 8'hE1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hE2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check4("rst_pre", 1'b1, 8'hE0, 1'b1, 3'd3, 3'd1);
    drive(1'b0, 1'b1, 8'hE3, 1'b1, 1'b0);
    check("rst_low rdy", 16'(rdy4), 16'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check4("rst_post", 1'b0, 8'h00, 1'b0, 3'd0, 3'd0);
    check("rst_post rdy", 16'(rdy4), 16'd1);

    // Head stays stable while stalled and pushes continue
    drive(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 8'hF0 + 8'(i), 1'b0, 1'b0);
      check($sformatf("stall%0d dat", i), 16'(dat4), 16'h5A);
      check($sformatf("stall%0d last", i), 16'(last4), 16'd1);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check4("stall_release", 1'b1, 8'h5A, 1'b1, 3'd4, 3'd1);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check4("stall_next", 1'b1, 8'hF0, 1'b0, 3'd3, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
